// File: rtl/multi_button_debouncer_pkg.sv
// Shared defaults and types for the multi-channel button debouncer.
// Default divider turns a 12 MHz clock into a 1 kHz sample tick.
package multi_button_debouncer_pkg;

  localparam int unsigned DEFAULT_CLK_HZ       = 12_000_000;
  localparam int unsigned DEFAULT_TICK_HZ      = 1_000;
  localparam int unsigned DEFAULT_DIV          = DEFAULT_CLK_HZ / DEFAULT_TICK_HZ;
  localparam int unsigned DEFAULT_STABLE_TICKS = 20;
  localparam int unsigned DEFAULT_LONG_TICKS   = 1000;

  // Per-channel event strobes, one clk wide each
  typedef struct packed {
    logic press;
    logic rel;
    logic hold;
  } ch_evt_t;

  // Bits needed to hold 0..max_v, never less than one
  function automatic int unsigned cnt_w(input int unsigned max_v);
    return (max_v == 0) ? 1 : 32'($clog2(max_v + 1));
  endfunction

endpackage

// File: rtl/multi_button_debouncer_channel.sv
// One button channel: 2-flop synchroniser, stability counter, level and edge pulses.
// Hold counter and long-press strobe exist only with MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN.
module debounce_channel
  import multi_button_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS
`ifdef MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN
  , parameter int unsigned LONG_TICKS = DEFAULT_LONG_TICKS
`endif
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_tick,
  input  logic    i_b,
  output logic    o_level,
  output ch_evt_t o_evt
);

  localparam int unsigned SW = cnt_w(STABLE_TICKS - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [SW-1:0] r_stab;
  logic          r_press;
  logic          r_rel;
  logic          w_long;
  logic          w_mismatch;
  logic          w_accept;

  assign w_mismatch = r_s2 ^ r_level;
  assign w_accept   = i_tick & w_mismatch & (r_stab == SW'(STABLE_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_b;
      r_s2 <= r_s1;
    end
  end

  // Counts consecutive mismatching ticks; clears on a match or on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stab <= '0;
    end else if (i_tick) begin
      if (!w_mismatch || w_accept) begin
        r_stab <= '0;
      end else begin
        r_stab <= r_stab + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_level <= r_level ^ w_accept;
      r_press <= w_accept & ~r_level;
      r_rel   <= w_accept & r_level;
    end
  end

`ifdef MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned HW = cnt_w(LONG_TICKS);

  logic [HW-1:0] r_hold;
  logic          r_long;
  logic          w_hold_done;

  assign w_hold_done = i_tick & r_level & (r_hold == HW'(LONG_TICKS - 1));

  // Saturating hold counter so the long strobe fires once per press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= w_hold_done;
      if (!r_level) begin
        r_hold <= '0;
      end else if (i_tick && (r_hold != HW'(LONG_TICKS))) begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  assign w_long = r_long;
`else
  assign w_long = 1'b0;
`endif

  assign o_level = r_level;
  assign o_evt   = '{press: r_press, rel: r_rel, hold: w_long};

endmodule

// File: rtl/multi_button_debouncer.sv
// N_CH independent button debouncers sharing one sample-tick prescaler.
// Long-press detection is enabled by defining MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN.
module multi_button_debouncer
  import multi_button_debouncer_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DIV          = DEFAULT_DIV,
  parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter int unsigned LONG_TICKS   = DEFAULT_LONG_TICKS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] b_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic            tick
);

  localparam int unsigned PW = cnt_w(DIV - 1);

  if ((N_CH < 1) || (N_CH > 32) || (DIV < 1) || (STABLE_TICKS < 1) || (LONG_TICKS < 1)) begin : g_bad_cfg
    $error("multi_button_debouncer: parameter out of range");
  end

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_cnt_nxt;
  logic          r_tick;

  assign w_cnt_nxt = (r_cnt == PW'(DIV - 1)) ? '0 : r_cnt + PW'(1);

  // Tick is registered from the next count so it stays low throughout reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == PW'(DIV - 1));
    end
  end

  assign tick = r_tick;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    ch_evt_t w_evt;
    logic    w_level;

    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
`ifdef MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN
      , .LONG_TICKS(LONG_TICKS)
`endif
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (r_tick),
      .i_b     (b_in[g]),
      .o_level (w_level),
      .o_evt   (w_evt)
    );

    assign level[g]         = w_level;
    assign press_pulse[g]   = w_evt.press;
    assign release_pulse[g] = w_evt.rel;
    assign long_pulse[g]    = w_evt.hold;
  end

endmodule
